axis_packet_rr_arbiter: RTL
===========================

# axis_packet_rr_arbiter

Packet-level round-robin arbiter that merges `NUM_INPUTS` AXI Stream sources onto one output stream. It is the many-to-one counterpart of the tdest-routed 1-to-N switch, placed in front of shared egress resources such as a network port or a DMA write channel. A grant is held from the first beat of a packet until its `tlast` beat is accepted, so packets are never interleaved. The output passes through one register stage.

## Interface
- `AXIS_BUS_WIDTH`, 64: tdata width in bits. Must be a multiple of 8.
- `AXIS_TID_WIDTH`, 1: tid width.
- `AXIS_TDEST_WIDTH`, 1: tdest width.
- `AXIS_TUSER_WIDTH`, 1: tuser width.
- `NUM_INPUTS`, 4: number of sources, 2 to 32.
- `TID_FROM_PORT`, 0: when 1, the output tid is the granted input index, zero-extended or truncated to `AXIS_TID_WIDTH`. When 0, the input tid passes through.
- `aclk`  in  1  clock; all ports are synchronous to it.
- `aresetn`  in  1  reset, synchronous, active-low.
- `s_axis_tdata`  in  `NUM_INPUTS*AXIS_BUS_WIDTH`  packed source data; slice i belongs to input i.
- `s_axis_tkeep`  in  `NUM_INPUTS*AXIS_BUS_WIDTH/8`  packed tkeep.
- `s_axis_tid`, `s_axis_tdest`, `s_axis_tuser`  in  `NUM_INPUTS*width`  packed sideband.
- `s_axis_tlast`, `s_axis_tvalid`  in  `NUM_INPUTS`  per-input flags.
- `s_axis_tready`  out  `NUM_INPUTS`  per-input ready.
- `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tid`, `m_axis_tdest`, `m_axis_tuser`, `m_axis_tlast`, `m_axis_tvalid`  out  (single-stream widths)  merged output.
- `m_axis_tready`  in  1  output ready.
- `grant_idx`  out  `$clog2(NUM_INPUTS)`  current grant, for debug and statistics.
- `grant_active`  out  1  high while the arbiter is in LOCKED.

## Operation
- There are two states:
  - IDLE: no grant.
  - LOCKED: `grant_idx` owns the input side.
- IDLE behaviour:
  - If any `s_axis_tvalid` is high, the arbiter picks the first asserted input starting at `rr_ptr` and wrapping modulo `NUM_INPUTS`.
  - It registers that index into `grant_idx` and moves to LOCKED.
  - No beat is accepted in IDLE.
- LOCKED behaviour:
  - `s_axis_tready[grant_idx]` = `!m_axis_tvalid || m_axis_tready`. All other readys are 0.
  - An accepted beat is loaded into the output register.
  - When an accepted beat has `tlast`=1, the arbiter sets `rr_ptr` = `grant_idx`+1, wrapping to 0 past `NUM_INPUTS`-1, and returns to IDLE.
- Output register:
  - Loaded on input accept.
  - If there is no accept, `m_axis_tvalid` clears when `m_axis_tready` is high.
  - Data holds stable while `m_axis_tvalid` && !`m_axis_tready`.
- A granted source that deasserts tvalid mid-packet keeps the grant. Grants are never revoked and there is no timeout.
- tkeep, tdest and tuser pass through unmodified. tid is handled per `TID_FROM_PORT`.

## Timing
- Reset values:
  - All `m_axis_*` = 0.
  - `s_axis_tready` = 0.
  - `grant_idx` = 0.
  - `grant_active` = 0.
  - State = IDLE.
  - `rr_ptr` = 0.
- Reset asserted mid-packet aborts the packet: the output register clears and no partial tail is emitted afterwards.
- Arbitration latency: tvalid first seen high in IDLE at cycle t gives LOCKED with tready high at t+1. The first beat appears on `m_axis` at t+2.
- Throughput:
  - One beat per cycle within a packet while `m_axis_tready` is held high.
  - One idle input cycle between consecutive packets, for re-arbitration. The output may still be draining during it.
- Single-beat packet (tvalid and tlast on the same beat): the arbiter occupies LOCKED for exactly one cycle.
- Simultaneous requests: round-robin order is strict. Once it starts a packet, a continuously requesting input waits at most `NUM_INPUTS`-1 packets before its next grant.

## Structure
- Package `axis_arb_pkg` holds:
  - the `arb_state_t` enum {IDLE, LOCKED};
  - function `rr_pick(req, ptr)`, which returns the index and a found flag.
- Sub-module `rr_priority_picker`: purely combinational rotate, priority-encode, un-rotate logic parameterised by `NUM_INPUTS`. It is reusable by future N-to-N switches.

## Test plan
- Reset check: assert aresetn=0 for 3 cycles with all inputs valid. Every output and readys must be 0, and after release the first grant goes to input 0.
- Fairness: 4 inputs all request continuously with 3-beat packets. Grants must run 0,1,2,3,0. Every output packet is contiguous with tlast on beats 3, 6, 9…
- Backpressure: `m_axis_tready` toggles 1010 during a packet of data 0xA0..0xA7. The output must be 0xA0..0xA7 in order, with no drops or duplicates and data stable while stalled.
- Stall within grant:
  - Input 2 sends 2 beats, drops tvalid for 5 cycles, then finishes.
  - Input 1 requests throughout.
  - Input 1 must not be granted until input 2's tlast has been accepted.
- `TID_FROM_PORT`=1: a packet from input 3 with input tid=0 must appear on `m_axis_tid`=3 (`AXIS_TID_WIDTH`=2).
- Reset mid-packet: apply aresetn=0 after beat 2 of 5. Outputs must be 0 the next cycle, and after release arbitration restarts at input 0.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and round-robin pick function for the packet arbiter
//
// Holds the arbiter state enum and rr_pick(), the rotate / priority-encode /
// un-rotate search used by rr_priority_picker. rr_pick works on a fixed
// 32-wide request vector so one function serves every NUM_INPUTS from 2 to 32;
// the caller passes the live input count in n.

package axis_arb_pkg;

    localparam int RR_MAX_INPUTS = 32;
    localparam int RR_IDX_W      = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Returns the first asserted request at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_INPUTS-1:0] req,
        input logic [RR_IDX_W-1:0]      ptr,
        input int                       n
    );
        rr_pick_t                 res;
        logic [RR_MAX_INPUTS-1:0] rot;
        res = '0;
        rot = '0;
        // Rotate so that request[ptr] lands on bit 0.
        for (int k = 0; k < RR_MAX_INPUTS; k++) begin
            if (k < n) begin
                rot[k] = req[RR_IDX_W'((k + int'(ptr)) % n)];
            end
        end
        // Lowest rotated bit wins; scanning downward makes the last hit the winner.
        for (int k = RR_MAX_INPUTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                res.found = 1'b1;
                res.idx   = RR_IDX_W'((k + int'(ptr)) % n);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin request picker
//
// Purely combinational: finds the first asserted request starting at ptr_i and
// wrapping around NUM_INPUTS. Reusable by any arbiter or switch fabric.
//
// Ports:
//   req_i    [NUM_INPUTS]  request vector, one bit per source
//   ptr_i    [IDX_W]       index with highest priority this cycle
//   found_o                at least one request was asserted
//   idx_o    [IDX_W]       winning index (0 when found_o is low)

module rr_priority_picker
    import axis_arb_pkg::*;
#(
    parameter  int NUM_INPUTS = 4,
    localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req_i,
    input  logic [IDX_W-1:0]      ptr_i,
    output logic                  found_o,
    output logic [IDX_W-1:0]      idx_o
);

    rr_pick_t pick;

    always_comb begin
        pick    = rr_pick(RR_MAX_INPUTS'(req_i), RR_IDX_W'(ptr_i), NUM_INPUTS);
        found_o = pick.found;
        idx_o   = IDX_W'(pick.idx);
    end

endmodule

// File: rtl/axis_packet_rr_arbiter.sv
// rtl/axis_packet_rr_arbiter.sv - packet-level round-robin N-to-1 AXI Stream arbiter
//
// Merges NUM_INPUTS streams onto one output. A grant is taken in IDLE, held
// from the first beat of a packet until its tlast beat is accepted, and then
// the round-robin pointer moves to the input after the winner. The output
// passes through a single register stage.
//
// Ports:
//   aclk, aresetn              clock, synchronous active-low reset
//   s_axis_t*                  packed source streams, slice i = input i
//   s_axis_tready [NUM_INPUTS] only the granted input can see ready
//   m_axis_t*                  registered merged stream
//   grant_idx                  current / last grant index
//   grant_active               high while a packet owns the input side

module axis_packet_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int AXIS_BUS_WIDTH   = 64,
    parameter  int AXIS_TID_WIDTH   = 1,
    parameter  int AXIS_TDEST_WIDTH = 1,
    parameter  int AXIS_TUSER_WIDTH = 1,
    parameter  int NUM_INPUTS       = 4,
    parameter  int TID_FROM_PORT    = 0,
    localparam int KEEP_W           = AXIS_BUS_WIDTH / 8,
    localparam int IDX_W            = $clog2(NUM_INPUTS)
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,

    input  logic [NUM_INPUTS*AXIS_BUS_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_INPUTS*KEEP_W-1:0]           s_axis_tkeep,
    input  logic [NUM_INPUTS*AXIS_TID_WIDTH-1:0]   s_axis_tid,
    input  logic [NUM_INPUTS*AXIS_TDEST_WIDTH-1:0] s_axis_tdest,
    input  logic [NUM_INPUTS*AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_INPUTS-1:0]                  s_axis_tlast,
    input  logic [NUM_INPUTS-1:0]                  s_axis_tvalid,
    output logic [NUM_INPUTS-1:0]                  s_axis_tready,

    output logic [AXIS_BUS_WIDTH-1:0]              m_axis_tdata,
    output logic [KEEP_W-1:0]                      m_axis_tkeep,
    output logic [AXIS_TID_WIDTH-1:0]              m_axis_tid,
    output logic [AXIS_TDEST_WIDTH-1:0]            m_axis_tdest,
    output logic [AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
    output logic                                   m_axis_tlast,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,

    output logic [IDX_W-1:0]                       grant_idx,
    output logic                                   grant_active
);

    // Unpacked views of the per-input slices so the mux indexes by grant.
    logic [AXIS_BUS_WIDTH-1:0]   in_data  [NUM_INPUTS];
    logic [KEEP_W-1:0]           in_keep  [NUM_INPUTS];
    logic [AXIS_TID_WIDTH-1:0]   in_tid   [NUM_INPUTS];
    logic [AXIS_TDEST_WIDTH-1:0] in_tdest [NUM_INPUTS];
    logic [AXIS_TUSER_WIDTH-1:0] in_tuser [NUM_INPUTS];

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
        assign in_data[gi]  = s_axis_tdata[gi*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
        assign in_keep[gi]  = s_axis_tkeep[gi*KEEP_W +: KEEP_W];
        assign in_tid[gi]   = s_axis_tid[gi*AXIS_TID_WIDTH +: AXIS_TID_WIDTH];
        assign in_tdest[gi] = s_axis_tdest[gi*AXIS_TDEST_WIDTH +: AXIS_TDEST_WIDTH];
        assign in_tuser[gi] = s_axis_tuser[gi*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
    end

    arb_state_t                  state_q,  state_d;
    logic [IDX_W-1:0]            grant_q,  grant_d;
    logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;

    logic [AXIS_BUS_WIDTH-1:0]   m_data_q,  m_data_d;
    logic [KEEP_W-1:0]           m_keep_q,  m_keep_d;
    logic [AXIS_TID_WIDTH-1:0]   m_tid_q,   m_tid_d;
    logic [AXIS_TDEST_WIDTH-1:0] m_tdest_q, m_tdest_d;
    logic [AXIS_TUSER_WIDTH-1:0] m_tuser_q, m_tuser_d;
    logic                        m_last_q,  m_last_d;
    logic                        m_valid_q, m_valid_d;

    logic                        pick_found;
    logic [IDX_W-1:0]            pick_idx;
    logic                        out_ready;
    logic                        accept;
    logic [AXIS_TID_WIDTH-1:0]   sel_tid;

    rr_priority_picker #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_picker (
        .req_i   (s_axis_tvalid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_tid_d   = m_tid_q;
        m_tdest_d = m_tdest_q;
        m_tuser_d = m_tuser_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;

        // The output register can take a new beat when empty or draining.
        out_ready     = !m_valid_q || m_axis_tready;
        s_axis_tready = '0;
        if (state_q == LOCKED) begin
            s_axis_tready[grant_q] = out_ready;
        end
        accept = (state_q == LOCKED) && s_axis_tvalid[grant_q] && out_ready;

        sel_tid = (TID_FROM_PORT != 0) ? AXIS_TID_WIDTH'(grant_q) : in_tid[grant_q];

        case (state_q)
            IDLE: begin
                // Arbitration only; no beat moves in this cycle.
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Grant is held through source gaps; only the tlast accept releases it.
                if (accept && s_axis_tlast[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            m_data_d  = in_data[grant_q];
            m_keep_d  = in_keep[grant_q];
            m_tid_d   = sel_tid;
            m_tdest_d = in_tdest[grant_q];
            m_tuser_d = in_tuser[grant_q];
            m_last_d  = s_axis_tlast[grant_q];
            m_valid_d = 1'b1;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_tid_q   <= '0;
            m_tdest_q <= '0;
            m_tuser_q <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_tid_q   <= m_tid_d;
            m_tdest_q <= m_tdest_d;
            m_tuser_q <= m_tuser_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tid    = m_tid_q;
    assign m_axis_tdest  = m_tdest_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tvalid = m_valid_q;
    assign grant_idx     = grant_q;
    assign grant_active  = (state_q == LOCKED);

endmodule
